pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Instruction sequencer for the pico-MIPS core.
- Decides each cycle how the program counter moves: advance (+1), relative branch, or hold (relative branch by 0).
- Stalls the counter for multi-cycle multiply and for blocking input reads.
- Generates register-write and handshake strobes.
- Sits between the instruction decoder and the program counter instance.

Parameters:
AddrSz, 6, program address width; matches the program counter's AddrSz
MulCycles, 4, cycles spent in the multiply wait state; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op  input  3  decoded instruction class (op_class_e)
imm_offset  input  AddrSz  signed branch/jump offset from the instruction
zero_flag  input  1  ALU zero flag from the previous instruction
in_valid  input  1  external input word available
rel_branch  output  1  to program counter: add offset instead of 1
offset  output  AddrSz  to program counter: offset to add
reg_we  output  1  register-file write strobe
mul_busy  output  1  multiplier active; hold multiplier operands
in_ack  output  1  input word consumed this cycle
halted  output  1  core stopped

Behaviour:
- Registered state: FSM state (RUN, MUL_WAIT, IN_WAIT, HALT) and a 4-bit down-counter.
- All outputs are combinational from state, op, zero_flag and in_valid.
- The program counter updates on the next rising edge, so there is zero added latency.
- Reset (asynchronous, active-high): state=RUN, counter=0.
  - mul_busy=0 and halted=0 while reset is asserted.
  - Other outputs follow op decode in RUN.
  - The program counter instance must be reset by the same event.
- Hold encoding: rel_branch=1, offset=0.
- Whenever rel_branch=0, offset is driven to 0.
- In RUN, by op class:
  - ALU: reg_we=1, advance.
  - NOP: reg_we=0, advance.
  - BEQ: rel_branch=zero_flag, offset=imm_offset when zero_flag=1, else advance.
  - BNE: rel_branch=~zero_flag, same offset rule as BEQ.
  - JMP: rel_branch=1, offset=imm_offset.
  - MUL: hold, mul_busy=1, counter<=MulCycles-1, next state MUL_WAIT.
  - IN with in_valid=1: reg_we=1, in_ack=1, advance, stay in RUN.
  - IN with in_valid=0: hold, next state IN_WAIT.
  - HALT: hold, next state HALT.
- MUL_WAIT:
  - mul_busy=1 throughout.
  - counter!=0: hold, counter decrements.
  - counter==0: reg_we=1, advance, next state RUN.
  - MUL therefore takes 1+MulCycles cycles in total; there are exactly MulCycles MUL_WAIT cycles.
- IN_WAIT:
  - in_valid=0: hold.
  - in_valid=1: reg_we=1, in_ack=1, advance, next state RUN.
- HALT: hold and halted=1 every cycle until reset; op is ignored.
- in_valid outside an IN fetch or IN_WAIT is ignored: in_ack=0.
- in_ack is asserted for one cycle per consumed word.
- Address arithmetic wraps modulo 2^AddrSz in the program counter; the sequencer does no range checking.
- JMP with imm_offset=0 is a legal self-loop: state remains RUN.
- reset during MUL_WAIT or IN_WAIT aborts the operation:
  - no reg_we or in_ack is issued;
  - state is RUN from the first cycle after reset deassertion.
- Unused op encodings are treated as NOP.

Decomposition:
- Shared package pico_pkg holds:
  - op_class_e: ALU=0, MUL=1, BEQ=2, BNE=3, IN=4, JMP=5, HALT=6, NOP=7.
  - seq_state_e.
  - Default ADDR_SZ=6.
- No sub-module: the FSM and down-counter stay in one module.
- The integration test instantiates pc_sequencer plus the program counter.

Test Plan:
1. Straight-line ALU: op=ALU for 5 cycles after reset -> PC 0,1,2,3,4,5; reg_we=1 each cycle; rel_branch=0, offset=0.
2. Branches: at PC=10, BEQ imm=-3 (6'b111101) with zero_flag=1 -> PC=7; BNE with the same inputs -> PC=11; JMP imm=0 -> PC stays 10, state RUN.
3. Multiply, MulCycles=4: MUL at PC=3 -> PC holds 3 for 5 cycles; mul_busy=1 for those 5 cycles; single reg_we on the last; PC=4 next.
4. Blocking input: IN at PC=8, in_valid low for 3 cycles then high -> PC holds 8; one-cycle in_ack and reg_we together; PC=9 next. Stray in_valid during ALU -> no in_ack.
5. Halt and reset: HALT at PC=20 -> halted=1, PC frozen at 20 for 10 cycles despite op changes. Async reset pulse mid-cycle -> halted=0 immediately, PC=0.
6. Reset mid-MUL: MUL, reset asserted in the second MUL_WAIT cycle -> no reg_we, mul_busy=0 during reset, state RUN and PC=0 after release.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared definitions for the pico-MIPS core: instruction classes, sequencer
// states and the default program address width.
package pico_pkg;

    localparam int ADDR_SZ = 6;

    typedef enum logic [2:0] {
        OP_ALU  = 3'd0,
        OP_MUL  = 3'd1,
        OP_BEQ  = 3'd2,
        OP_BNE  = 3'd3,
        OP_IN   = 3'd4,
        OP_JMP  = 3'd5,
        OP_HALT = 3'd6,
        OP_NOP  = 3'd7
    } op_class_e;

    typedef enum logic [1:0] {
        SEQ_RUN      = 2'd0,
        SEQ_MUL_WAIT = 2'd1,
        SEQ_IN_WAIT  = 2'd2,
        SEQ_HALT     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Instruction sequencer: chooses advance / relative branch / hold for the
// program counter each cycle, stalls for multiply and blocking input reads.
module pc_sequencer
    import pico_pkg::*;
#(
    parameter int AddrSz    = ADDR_SZ,
    parameter int MulCycles = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [AddrSz-1:0] imm_offset,
    input  logic              zero_flag,
    input  logic              in_valid,
    output logic              rel_branch,
    output logic [AddrSz-1:0] offset,
    output logic              reg_we,
    output logic              mul_busy,
    output logic              in_ack,
    output logic              halted
);

    localparam logic [1:0] ST_RUN      = SEQ_RUN;
    localparam logic [1:0] ST_MUL_WAIT = SEQ_MUL_WAIT;
    localparam logic [1:0] ST_IN_WAIT  = SEQ_IN_WAIT;
    localparam logic [1:0] ST_HALT     = SEQ_HALT;

    // Counter is loaded one below MulCycles so that the wait state lasts
    // exactly MulCycles cycles, the last of which (count 0) retires the result.
    localparam logic [3:0] MUL_LOAD = 4'(MulCycles - 1);

    logic [1:0]        state_r;
    logic [1:0]        next_state_s;
    logic [3:0]        count_r;
    logic [3:0]        next_count_s;
    logic              rel_branch_s;
    logic [AddrSz-1:0] offset_s;
    logic              reg_we_s;
    logic              mul_busy_s;
    logic              in_ack_s;
    logic              halted_s;

    // Next-state and output decode from state, op, zero_flag and in_valid.
    always_comb begin
        next_state_s = state_r;
        next_count_s = count_r;
        rel_branch_s = 1'b0;
        offset_s     = '0;
        reg_we_s     = 1'b0;
        mul_busy_s   = 1'b0;
        in_ack_s     = 1'b0;
        halted_s     = 1'b0;

        case (state_r)
            ST_RUN: begin
                case (op_class_e'(op))
                    OP_ALU: begin
                        reg_we_s = 1'b1;
                    end
                    OP_BEQ: begin
                        if (zero_flag) begin
                            rel_branch_s = 1'b1;
                            offset_s     = imm_offset;
                        end else begin
                            rel_branch_s = 1'b0;
                        end
                    end
                    OP_BNE: begin
                        if (!zero_flag) begin
                            rel_branch_s = 1'b1;
                            offset_s     = imm_offset;
                        end else begin
                            rel_branch_s = 1'b0;
                        end
                    end
                    OP_JMP: begin
                        rel_branch_s = 1'b1;
                        offset_s     = imm_offset;
                    end
                    OP_MUL: begin
                        rel_branch_s = 1'b1;
                        mul_busy_s   = 1'b1;
                        next_count_s = MUL_LOAD;
                        next_state_s = ST_MUL_WAIT;
                    end
                    OP_IN: begin
                        if (in_valid) begin
                            reg_we_s = 1'b1;
                            in_ack_s = 1'b1;
                        end else begin
                            rel_branch_s = 1'b1;
                            next_state_s = ST_IN_WAIT;
                        end
                    end
                    OP_HALT: begin
                        rel_branch_s = 1'b1;
                        next_state_s = ST_HALT;
                    end
                    OP_NOP: begin
                        reg_we_s = 1'b0;
                    end
                    default: begin
                        reg_we_s = 1'b0;
                    end
                endcase
            end

            ST_MUL_WAIT: begin
                mul_busy_s = 1'b1;
                if (count_r != 4'd0) begin
                    rel_branch_s = 1'b1;
                    next_count_s = count_r - 4'd1;
                end else begin
                    reg_we_s     = 1'b1;
                    next_state_s = ST_RUN;
                end
            end

            ST_IN_WAIT: begin
                if (in_valid) begin
                    reg_we_s     = 1'b1;
                    in_ack_s     = 1'b1;
                    next_state_s = ST_RUN;
                end else begin
                    rel_branch_s = 1'b1;
                end
            end

            ST_HALT: begin
                rel_branch_s = 1'b1;
                halted_s     = 1'b1;
            end

            default: begin
                // Unreachable encoding: hold the PC and recover to RUN.
                rel_branch_s = 1'b1;
                next_state_s = ST_RUN;
                next_count_s = 4'd0;
            end
        endcase
    end

    // State and multiply down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
            count_r <= 4'd0;
        end else begin
            state_r <= next_state_s;
            count_r <= next_count_s;
        end
    end

    assign rel_branch = rel_branch_s;
    assign offset     = offset_s;
    assign reg_we     = reg_we_s;
    assign in_ack     = in_ack_s;
    // The RUN decode of MUL would otherwise show mul_busy while reset is held.
    assign mul_busy   = mul_busy_s & ~reset;
    assign halted     = halted_s & ~reset;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer with a behavioural program counter attached:
// decode table, directed multi-cycle sequences and a randomized model run.
module tb_pc_sequencer;
    import pico_pkg::*;

    localparam int MUL_C = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] op;
    logic [5:0] imm_offset;
    logic       zero_flag;
    logic       in_valid;
    logic       rel_branch;
    logic [5:0] offset;
    logic       reg_we;
    logic       mul_busy;
    logic       in_ack;
    logic       halted;
    logic [5:0] pc;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model state: remaining multiply-wait cycles, input wait, halt.
    int         m_mul_left;
    bit         m_in_wait;
    bit         m_halted;
    logic [5:0] m_pc;

    typedef struct {
        logic [2:0] op;
        logic [5:0] imm;
        logic       zf;
        logic       inv;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[13];

    pc_sequencer #(.AddrSz(6), .MulCycles(MUL_C)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .imm_offset (imm_offset),
        .zero_flag  (zero_flag),
        .in_valid   (in_valid),
        .rel_branch (rel_branch),
        .offset     (offset),
        .reg_we     (reg_we),
        .mul_busy   (mul_busy),
        .in_ack     (in_ack),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 6'd0;
        else       pc <= rel_branch ? pc + offset : pc + 6'd1;
    end

    function automatic logic [9:0] pk(logic rel, logic [5:0] off, logic we,
                                      logic ack, logic busy, logic hl);
        return {rel, off, we, ack, busy, hl};
    endfunction

    function automatic vec_t mk(logic [2:0] o, logic [5:0] i, logic z, logic v,
                                logic [9:0] e);
        vec_t r;
        r.op = o; r.imm = i; r.zf = z; r.inv = v; r.exp = e;
        return r;
    endfunction

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b (rel,off6,we,ack,busy,halt)", nm, act, exp);
    endtask

    task automatic check_pc(input string nm, input logic [5:0] exp);
        chk_cnt++;
        if (pc === exp) pass_cnt++;
        else $display("FAIL %s: pc got %0d expected %0d", nm, pc, exp);
    endtask

    function automatic logic [9:0] outs();
        return {rel_branch, offset, reg_we, in_ack, mul_busy, halted};
    endfunction

    // Called at posedge+1: drive, compare, advance one clock edge.
    task automatic step(input logic [2:0] o, input logic [5:0] i, input logic z,
                        input logic v, input string nm, input logic [9:0] e);
        op = o; imm_offset = i; zero_flag = z; in_valid = v;
        #1;
        check(nm, outs(), e);
        @(posedge clk);
        #1;
    endtask

    task automatic goto_pc(input logic [5:0] target);
        logic [5:0] d;
        d = target - pc;
        step(OP_JMP, d, 1'b0, 1'b0, "goto", pk(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0));
        check_pc("goto_pc", target);
    endtask

    task automatic model_reset();
        m_mul_left = 0; m_in_wait = 0; m_halted = 0; m_pc = 6'd0;
    endtask

    task automatic model_eval(input logic [2:0] o, input logic [5:0] i, input logic z,
                              input logic v, output logic [9:0] e);
        logic rel, we, ack, busy, hl;
        logic [5:0] off;
        rel = 0; we = 0; ack = 0; busy = 0; hl = 0; off = 6'd0;
        if (m_halted) begin
            rel = 1; hl = 1;
        end else if (m_mul_left > 0) begin
            busy = 1;
            m_mul_left--;
            if (m_mul_left == 0) we = 1;
            else rel = 1;
        end else if (m_in_wait) begin
            if (v) begin we = 1; ack = 1; m_in_wait = 0; end
            else rel = 1;
        end else begin
            case (o)
                OP_ALU:  we = 1;
                OP_BEQ:  if (z)  begin rel = 1; off = i; end
                OP_BNE:  if (!z) begin rel = 1; off = i; end
                OP_JMP:  begin rel = 1; off = i; end
                OP_MUL:  begin rel = 1; busy = 1; m_mul_left = MUL_C; end
                OP_IN:   if (v) begin we = 1; ack = 1; end
                         else begin rel = 1; m_in_wait = 1; end
                OP_HALT: begin rel = 1; m_halted = 1; end
                default: ;
            endcase
        end
        e = pk(rel, off, we, ack, busy, hl);
        m_pc = rel ? m_pc + off : m_pc + 6'd1;
    endtask

    initial begin
        logic [9:0] e;
        logic [2:0] ro;

        vecs[0]  = mk(OP_ALU,  6'h05, 1'b0, 1'b0, pk(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vecs[1]  = mk(OP_NOP,  6'h09, 1'b1, 1'b0, pk(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[2]  = mk(OP_BEQ,  6'h3d, 1'b1, 1'b0, pk(1'b1, 6'h3d, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[3]  = mk(OP_BEQ,  6'h3d, 1'b0, 1'b0, pk(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[4]  = mk(OP_BNE,  6'h05, 1'b0, 1'b0, pk(1'b1, 6'h05, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[5]  = mk(OP_BNE,  6'h05, 1'b1, 1'b0, pk(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[6]  = mk(OP_JMP,  6'h00, 1'b1, 1'b0, pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[7]  = mk(OP_JMP,  6'h20, 1'b0, 1'b1, pk(1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[8]  = mk(OP_MUL,  6'h07, 1'b0, 1'b0, pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        vecs[9]  = mk(OP_IN,   6'h11, 1'b0, 1'b1, pk(1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        vecs[10] = mk(OP_IN,   6'h11, 1'b0, 1'b0, pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[11] = mk(OP_HALT, 6'h2a, 1'b1, 1'b0, pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        vecs[12] = mk(OP_ALU,  6'h01, 1'b0, 1'b1, pk(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0));

        // Reset state: MUL decoded in RUN but mul_busy masked.
        reset = 1'b1; op = OP_MUL; imm_offset = 6'd0; zero_flag = 1'b0; in_valid = 1'b0;
        #2;
        check("reset_outs", outs(), pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        check_pc("reset_pc", 6'd0);
        op = OP_NOP;
        #10 reset = 1'b0;
        @(posedge clk); #1;
        check_pc("after_reset_pc", 6'd1);

        // Decode table in RUN; op returns to NOP before each edge.
        for (int k = 0; k < 13; k++) begin
            op = vecs[k].op; imm_offset = vecs[k].imm;
            zero_flag = vecs[k].zf; in_valid = vecs[k].inv;
            #1;
            check($sformatf("table[%0d]", k), outs(), vecs[k].exp);
            op = OP_NOP; in_valid = 1'b0;
            @(posedge clk); #1;
        end

        // Straight-line ALU from PC 0.
        reset = 1'b1; #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_pc($sformatf("alu_pc%0d", k), 6'(k));
            step(OP_ALU, 6'd0, 1'b0, 1'b0, "alu", pk(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        check_pc("alu_pc5", 6'd5);

        // Branches at PC 10.
        goto_pc(6'd10);
        step(OP_BEQ, 6'h3d, 1'b1, 1'b0, "beq_taken", pk(1'b1, 6'h3d, 1'b0, 1'b0, 1'b0, 1'b0));
        check_pc("beq_pc", 6'd7);
        goto_pc(6'd10);
        step(OP_BNE, 6'h3d, 1'b1, 1'b0, "bne_nt", pk(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        check_pc("bne_pc", 6'd11);
        goto_pc(6'd10);
        step(OP_JMP, 6'h00, 1'b0, 1'b0, "jmp0", pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        check_pc("jmp0_pc", 6'd10);
        step(OP_ALU, 6'h00, 1'b0, 1'b0, "jmp0_run", pk(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        check_pc("jmp0_next", 6'd11);

        // Multiply at PC 3: five held cycles, reg_we on the last.
        goto_pc(6'd3);
        for (int k = 0; k < MUL_C + 1; k++) begin
            check_pc($sformatf("mul_pc%0d", k), 6'd3);
            step((k == 0) ? OP_MUL : OP_NOP, 6'd0, 1'b0, 1'b0, $sformatf("mul%0d", k),
                 pk((k != MUL_C), 6'h00, (k == MUL_C), 1'b0, 1'b1, 1'b0));
        end
        check_pc("mul_done_pc", 6'd4);
        step(OP_NOP, 6'd0, 1'b0, 1'b0, "mul_after", pk(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));

        // Blocking input at PC 8.
        goto_pc(6'd8);
        step(OP_IN, 6'd0, 1'b0, 1'b0, "in_wait0", pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k < 3; k++) begin
            check_pc($sformatf("in_pc%0d", k), 6'd8);
            step(OP_NOP, 6'd0, 1'b0, 1'b0, $sformatf("in_wait%0d", k),
                 pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        step(OP_NOP, 6'd0, 1'b0, 1'b1, "in_ack", pk(1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0));
        check_pc("in_done_pc", 6'd9);
        step(OP_ALU, 6'd0, 1'b0, 1'b1, "stray_inv", pk(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0));

        // Halt at PC 20, then an async reset pulse inside a cycle.
        goto_pc(6'd20);
        step(OP_HALT, 6'd0, 1'b0, 1'b0, "halt_fetch", pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 10; k++) begin
            step(3'($urandom_range(0, 7)), 6'($urandom), 1'($urandom), 1'($urandom),
                 $sformatf("halted%0d", k), pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1));
            check_pc($sformatf("halt_pc%0d", k), 6'd20);
        end
        op = OP_NOP; in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("halt_reset", outs(), pk(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        check_pc("halt_reset_pc", 6'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        check_pc("halt_release_pc", 6'd1);

        // Reset in the second MUL_WAIT cycle aborts the multiply.
        goto_pc(6'd12);
        step(OP_MUL, 6'd0, 1'b0, 1'b0, "rmul0", pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        step(OP_NOP, 6'd0, 1'b0, 1'b0, "rmul1", pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        op = OP_MUL; reset = 1'b1;
        #1;
        check("rmul_reset", outs(), pk(1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        op = OP_NOP;
        #1;
        check("rmul_reset_nop", outs(), pk(1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        check_pc("rmul_pc", 6'd0);
        reset = 1'b0;
        step(OP_ALU, 6'd0, 1'b0, 1'b0, "rmul_run", pk(1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        check_pc("rmul_next_pc", 6'd1);

        // Randomized run against the behavioural model.
        reset = 1'b1; #1 reset = 1'b0;
        model_reset();
        for (int k = 0; k < 400; k++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                reset = 1'b1; #1 reset = 1'b0;
                model_reset();
            end
            ro = 3'($urandom_range(0, 7));
            if (ro == OP_HALT && $urandom_range(0, 3) != 0) ro = OP_NOP;
            op = ro; imm_offset = 6'($urandom); zero_flag = 1'($urandom);
            in_valid = 1'($urandom);
            model_eval(op, imm_offset, zero_flag, in_valid, e);
            #1;
            check($sformatf("rand%0d", k), outs(), e);
            @(posedge clk); #1;
            check_pc($sformatf("rand_pc%0d", k), m_pc);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
